// File: rtl/alu_ctrl_pkg.sv
// ALU control codes and requester ids shared by blocks that sit in front of the ALU.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MOD = 4'b0010,
    OP_MUL = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_OR  = 4'b0110,
    OP_AND = 4'b0111,
    OP_XOR = 4'b1000
  } alu_op_e;

  localparam logic [3:0] OP_MAX = 4'b1000;

  localparam logic REQ_EX = 1'b0;
  localparam logic REQ_AG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    gnt_id_o = gnt_o[1];
  end

  // Loser of this grant gets priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = ~gnt_id_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage and the address/branch unit:
// round-robin accept, one issue register, one response slot per requester.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned       WIDTH  = 32,
  parameter int unsigned       OP_W   = 4,
  parameter logic [OP_W-1:0]   OP_MAX = OP_W'(alu_ctrl_pkg::OP_MAX)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             rq0_valid,
  output logic             rq0_ready,
  input  logic [OP_W-1:0]  rq0_op,
  input  logic [WIDTH-1:0] rq0_a,
  input  logic [WIDTH-1:0] rq0_b,
  input  logic             rq1_valid,
  output logic             rq1_ready,
  input  logic [OP_W-1:0]  rq1_op,
  input  logic [WIDTH-1:0] rq1_a,
  input  logic [WIDTH-1:0] rq1_b,
  output logic             rs0_valid,
  input  logic             rs0_ready,
  output logic [WIDTH-1:0] rs0_result1,
  output logic [WIDTH-1:0] rs0_result2,
  output logic             rs0_zero,
  output logic             rs0_err,
  output logic             rs1_valid,
  input  logic             rs1_ready,
  output logic [WIDTH-1:0] rs1_result1,
  output logic [WIDTH-1:0] rs1_result2,
  output logic             rs1_zero,
  output logic             rs1_err,
  output logic [OP_W-1:0]  alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result1,
  input  logic [WIDTH-1:0] alu_result2,
  input  logic             alu_zero
);

  logic             stage_valid_q, stage_valid_d;
  logic             stage_owner_q, stage_owner_d;
  logic [OP_W-1:0]  stage_op_q, stage_op_d;
  logic [WIDTH-1:0] stage_a_q, stage_a_d;
  logic [WIDTH-1:0] stage_b_q, stage_b_d;

  logic [1:0]            rs_valid_q, rs_valid_d;
  logic [1:0][WIDTH-1:0] rs_result1_q, rs_result1_d;
  logic [1:0][WIDTH-1:0] rs_result2_q, rs_result2_d;
  logic [1:0]            rs_zero_q, rs_zero_d;
  logic [1:0]            rs_err_q, rs_err_d;

  logic [1:0] rs_ready;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       adv;
  logic       can_accept;
  logic       accept;

  assign rs_ready = {rs1_ready, rs0_ready};

  // Stage drains into its owner's slot when that slot is empty or being consumed.
  assign adv        = stage_valid_q &
                      (~rs_valid_q[stage_owner_q] | rs_ready[stage_owner_q]);
  assign can_accept = (~stage_valid_q | adv) & ~Reset;
  assign accept     = |gnt;

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .req_i    ({rq1_valid, rq0_valid}),
    .en_i     (can_accept),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign rq0_ready = gnt[REQ_EX];
  assign rq1_ready = gnt[REQ_AG];

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_owner_d = stage_owner_q;
    stage_op_d    = stage_op_q;
    stage_a_d     = stage_a_q;
    stage_b_d     = stage_b_q;
    if (accept) begin
      stage_valid_d = 1'b1;
      stage_owner_d = gnt_id;
      stage_op_d    = gnt_id ? rq1_op : rq0_op;
      stage_a_d     = gnt_id ? rq1_a  : rq0_a;
      stage_b_d     = gnt_id ? rq1_b  : rq0_b;
    end else if (adv) begin
      stage_valid_d = 1'b0;
    end
  end

  // Refill after consume in the same cycle: the refill is written last and wins.
  always_comb begin
    rs_valid_d   = rs_valid_q;
    rs_result1_d = rs_result1_q;
    rs_result2_d = rs_result2_q;
    rs_zero_d    = rs_zero_q;
    rs_err_d     = rs_err_q;
    for (int i = 0; i < 2; i++) begin
      if (rs_valid_q[i] && rs_ready[i]) rs_valid_d[i] = 1'b0;
      if (adv && (stage_owner_q == 1'(i))) begin
        rs_valid_d[i]   = 1'b1;
        rs_result1_d[i] = alu_result1;
        rs_result2_d[i] = alu_result2;
        rs_zero_d[i]    = alu_zero;
        rs_err_d[i]     = (stage_op_q > OP_MAX);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stage_valid_q <= 1'b0;
      stage_owner_q <= 1'b0;
      stage_op_q    <= '0;
      stage_a_q     <= '0;
      stage_b_q     <= '0;
      rs_valid_q    <= '0;
      rs_result1_q  <= '0;
      rs_result2_q  <= '0;
      rs_zero_q     <= '0;
      rs_err_q      <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_owner_q <= stage_owner_d;
      stage_op_q    <= stage_op_d;
      stage_a_q     <= stage_a_d;
      stage_b_q     <= stage_b_d;
      rs_valid_q    <= rs_valid_d;
      rs_result1_q  <= rs_result1_d;
      rs_result2_q  <= rs_result2_d;
      rs_zero_q     <= rs_zero_d;
      rs_err_q      <= rs_err_d;
    end
  end

  assign alu_ctrl = stage_valid_q ? stage_op_q : '0;
  assign alu_a    = stage_valid_q ? stage_a_q  : '0;
  assign alu_b    = stage_valid_q ? stage_b_q  : '0;

  assign rs0_valid   = rs_valid_q[0];
  assign rs0_result1 = rs_result1_q[0];
  assign rs0_result2 = rs_result2_q[0];
  assign rs0_zero    = rs_zero_q[0];
  assign rs0_err     = rs_err_q[0];
  assign rs1_valid   = rs_valid_q[1];
  assign rs1_result1 = rs_result1_q[1];
  assign rs1_result2 = rs_result2_q[1];
  assign rs1_zero    = rs_zero_q[1];
  assign rs1_err     = rs_err_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_share_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        rq0_valid, rq0_ready, rq1_valid, rq1_ready;
  logic [3:0]  rq0_op, rq1_op;
  logic [31:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic        rs0_valid, rs0_ready, rs0_zero, rs0_err;
  logic        rs1_valid, rs1_ready, rs1_zero, rs1_err;
  logic [31:0] rs0_result1, rs0_result2, rs1_result1, rs1_result2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result1, alu_result2;
  logic        alu_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  alu_share_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op), .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rs0_valid(rs0_valid), .rs0_ready(rs0_ready), .rs0_result1(rs0_result1),
    .rs0_result2(rs0_result2), .rs0_zero(rs0_zero), .rs0_err(rs0_err),
    .rs1_valid(rs1_valid), .rs1_ready(rs1_ready), .rs1_result1(rs1_result1),
    .rs1_result2(rs1_result2), .rs1_zero(rs1_zero), .rs1_err(rs1_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result1(alu_result1), .alu_result2(alu_result2), .alu_zero(alu_zero)
  );

  // Reference ALU: illegal codes produce zero.
  logic [63:0] prod;
  always_comb begin
    prod        = {32'd0, alu_a} * {32'd0, alu_b};
    alu_result1 = 32'd0;
    alu_result2 = 32'd0;
    case (alu_ctrl)
      4'b0000: alu_result1 = alu_a + alu_b;
      4'b0001: alu_result1 = alu_a - alu_b;
      4'b0010: alu_result1 = (alu_b == 32'd0) ? alu_a : alu_a % alu_b;
      4'b0011: begin alu_result1 = prod[31:0]; alu_result2 = prod[63:32]; end
      4'b0100: alu_result1 = alu_a << alu_b[4:0];
      4'b0101: alu_result1 = alu_a >> alu_b[4:0];
      4'b0110: alu_result1 = alu_a | alu_b;
      4'b0111: alu_result1 = alu_a & alu_b;
      4'b1000: alu_result1 = alu_a ^ alu_b;
      default: alu_result1 = 32'd0;
    endcase
    alu_zero = (alu_result1 == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    rq0_valid = 0; rq0_op = 0; rq0_a = 0; rq0_b = 0;
    rq1_valid = 0; rq1_op = 0; rq1_a = 0; rq1_b = 0;
    rs0_ready = 0; rs1_ready = 0;

    // Reset state
    tick();
    rq0_valid = 1; #1;
    chk("rst_rq0_ready", rq0_ready, 0);
    tick();
    Reset = 0; rq0_valid = 0; #1;
    chk("rst_rs0_valid", rs0_valid, 0);
    chk("rst_rs1_valid", rs1_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rs0_result1", rs0_result1, 0);
    chk("rst_rs1_err", rs1_err, 0);

    // Single op: ADD 2+2
    rs0_ready = 1; rs1_ready = 1;
    rq0_valid = 1; rq0_op = 4'b0000; rq0_a = 2; rq0_b = 2; #1;
    chk("single_rq0_ready", rq0_ready, 1);
    chk("single_rq1_ready", rq1_ready, 0);
    tick();
    rq0_valid = 0; #1;
    chk("single_alu_ctrl", alu_ctrl, 4'b0000);
    chk("single_alu_a", alu_a, 2);
    chk("single_rs0_early", rs0_valid, 0);
    tick();
    chk("single_rs0_valid", rs0_valid, 1);
    chk("single_result1", rs0_result1, 4);
    chk("single_zero", rs0_zero, 0);
    chk("single_err", rs0_err, 0);
    chk("single_rs1_valid", rs1_valid, 0);
    tick();
    chk("single_rs0_done", rs0_valid, 0);

    // Contention from a fresh reset
    do_reset();
    rq0_valid = 1; rq0_op = 4'b0001; rq0_a = 3; rq0_b = 3;
    rq1_valid = 1; rq1_op = 4'b0111; rq1_a = 32'h0F0F0F0F; rq1_b = 32'hF0F0F0F0; #1;
    chk("cont_rq0_ready", rq0_ready, 1);
    chk("cont_rq1_ready", rq1_ready, 0);
    tick();
    rq0_valid = 0; #1;
    chk("cont_rq1_ready2", rq1_ready, 1);
    tick();
    rq1_valid = 0; #1;
    chk("cont_rs0_valid", rs0_valid, 1);
    chk("cont_rs0_result1", rs0_result1, 0);
    chk("cont_rs0_zero", rs0_zero, 1);
    tick();
    chk("cont_rs1_valid", rs1_valid, 1);
    chk("cont_rs1_result1", rs1_result1, 0);
    chk("cont_rs1_zero", rs1_zero, 1);
    chk("cont_rs0_gone", rs0_valid, 0);
    rq0_valid = 1; rq0_op = 4'b0000; rq0_a = 1; rq0_b = 1;
    rq1_valid = 1; rq1_op = 4'b0000; rq1_a = 2; rq1_b = 2; #1;
    chk("cont2_rq0_ready", rq0_ready, 1);
    chk("cont2_rq1_ready", rq1_ready, 0);
    tick();
    rq0_valid = 0;
    tick();
    rq1_valid = 0;
    tick(); tick(); tick();

    // Backpressure on requester 1
    rs1_ready = 0;
    rq1_valid = 1; rq1_op = 4'b0110; rq1_a = 32'h0F0F0F0F; rq1_b = 32'hF0F0F0F0; #1;
    chk("bp_rq1_ready_or", rq1_ready, 1);
    tick();
    rq1_op = 4'b1000; rq1_a = 32'hAAAAAAAA; rq1_b = 32'hF0F0F0F0; #1;
    chk("bp_rq1_ready_xor", rq1_ready, 1);
    tick();
    rq1_op = 4'b0000; rq1_a = 5; rq1_b = 5;
    rq0_valid = 1; rq0_op = 4'b0000; rq0_a = 1; rq0_b = 1; #1;
    chk("bp_rq0_blocked", rq0_ready, 0);
    chk("bp_rq1_blocked", rq1_ready, 0);
    chk("bp_rs1_valid", rs1_valid, 1);
    chk("bp_rs1_or", rs1_result1, 32'hFFFFFFFF);
    tick();
    chk("bp_rq0_blocked2", rq0_ready, 0);
    chk("bp_rs1_hold", rs1_result1, 32'hFFFFFFFF);
    rs1_ready = 1; #1;
    chk("bp_rq0_free", rq0_ready, 1);
    chk("bp_rq1_lose", rq1_ready, 0);
    tick();
    rq0_valid = 0; #1;
    chk("bp_rs1_valid2", rs1_valid, 1);
    chk("bp_rs1_xor", rs1_result1, 32'h5A5A5A5A);
    chk("bp_rq1_ready3", rq1_ready, 1);
    tick();
    rq1_valid = 0; #1;
    chk("bp_rs1_empty", rs1_valid, 0);
    chk("bp_rs0_valid", rs0_valid, 1);
    chk("bp_rs0_result1", rs0_result1, 2);
    tick();
    chk("bp_rs1_last", rs1_result1, 10);
    chk("bp_rs1_last_v", rs1_valid, 1);
    tick(); tick();

    // Illegal op then legal op
    rq0_valid = 1; rq0_op = 4'b1011; rq0_a = 5; rq0_b = 3; #1;
    chk("ill_rq0_ready", rq0_ready, 1);
    tick();
    rq0_op = 4'b0000; rq0_a = 7; rq0_b = 8; #1;
    chk("ill_rq0_ready2", rq0_ready, 1);
    tick();
    rq0_valid = 0; #1;
    chk("ill_rs0_valid", rs0_valid, 1);
    chk("ill_rs0_err", rs0_err, 1);
    chk("ill_rs0_result1", rs0_result1, 0);
    tick();
    chk("ill_next_valid", rs0_valid, 1);
    chk("ill_next_err", rs0_err, 0);
    chk("ill_next_result1", rs0_result1, 15);
    tick();

    // Reset with stage and rs0 full
    rs0_ready = 0;
    rq0_valid = 1; rq0_op = 4'b0000; rq0_a = 1; rq0_b = 1;
    tick();
    rq0_a = 3; rq0_b = 3; #1;
    chk("rmf_rq0_ready", rq0_ready, 1);
    tick();
    rq0_valid = 0; #1;
    chk("rmf_rs0_full", rs0_valid, 1);
    chk("rmf_stage_full", alu_a, 3);
    Reset = 1;
    tick();
    Reset = 0; rs0_ready = 1; #1;
    chk("rmf_rs0_clr", rs0_valid, 0);
    chk("rmf_rs1_clr", rs1_valid, 0);
    chk("rmf_alu_a_clr", alu_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmf_no_stale", rs0_valid, 0);
    end
    rq0_valid = 1; rq0_op = 4'b0000; rq0_a = 0; rq0_b = 0;
    rq1_valid = 1; rq1_op = 4'b0000; rq1_a = 0; rq1_b = 0; #1;
    chk("rmf_ptr_rq0", rq0_ready, 1);
    chk("rmf_ptr_rq1", rq1_ready, 0);
    tick();
    rq0_valid = 0;
    tick();
    rq1_valid = 0;
    tick(); tick(); tick();

    // Throughput: three ops back to back on requester 0
    rq0_valid = 1; rq0_op = 4'b0011; rq0_a = 64; rq0_b = 4; #1;
    chk("tp_ready_mul", rq0_ready, 1);
    tick();
    rq0_op = 4'b0100; rq0_a = 1; rq0_b = 4; #1;
    chk("tp_ready_sll", rq0_ready, 1);
    tick();
    rq0_op = 4'b0101; rq0_a = 32'h80000000; rq0_b = 31; #1;
    chk("tp_ready_srl", rq0_ready, 1);
    chk("tp_mul_valid", rs0_valid, 1);
    chk("tp_mul_lo", rs0_result1, 256);
    chk("tp_mul_hi", rs0_result2, 0);
    tick();
    rq0_valid = 0; #1;
    chk("tp_sll_valid", rs0_valid, 1);
    chk("tp_sll", rs0_result1, 16);
    tick();
    chk("tp_srl_valid", rs0_valid, 1);
    chk("tp_srl", rs0_result1, 1);
    tick();
    chk("tp_drained", rs0_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU datapath between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-compare unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers the winning operation into an issue stage that drives the ALU, then captures the ALU outputs into that requester's response slot.
- One operation can be accepted per cycle. Latency from request accept to response valid is 2 cycles.

Parameters:
WIDTH, 32, operand and result width
OP_W, 4, ALU control code width
OP_MAX, 4'b1000, highest legal control code (XOR)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
rq0_valid  in  1  requester 0 request valid
rq0_ready  out  1  requester 0 request accepted this cycle
rq0_op  in  OP_W  ALU control code
rq0_a  in  WIDTH  operand A
rq0_b  in  WIDTH  operand B
rq1_valid, rq1_ready, rq1_op, rq1_a, rq1_b  (same as requester 0, for requester 1)
rs0_valid  out  1  requester 0 response valid
rs0_ready  in  1  requester 0 response consumed
rs0_result1  out  WIDTH  ALUResult1 (low word / primary result)
rs0_result2  out  WIDTH  ALUResult2 (high word of multiply)
rs0_zero  out  1  ALU Zero flag
rs0_err  out  1  illegal op code
rs1_valid, rs1_ready, rs1_result1, rs1_result2, rs1_zero, rs1_err  (same as requester 0, for requester 1)
alu_ctrl  out  OP_W  to ALU ALUControl
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_result1  in  WIDTH  from ALU
alu_result2  in  WIDTH  from ALU
alu_zero  in  1  from ALU

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; all state clears on the Clk edge where Reset=1.
- Reset values:
  - stage_valid=0, rr_ptr=0 (requester 0 has priority).
  - rs0_valid=rs1_valid=0; all rs*_result*, rs*_zero and rs*_err = 0.
  - alu_ctrl/alu_a/alu_b = 0.
  - rq0_ready=rq1_ready=0 while Reset=1.
- Issue stage: a single register holding {valid, owner id, op, a, b}.
  - alu_ctrl/alu_a/alu_b are driven from the issue stage when valid, otherwise 0.
  - No combinational path from rq* to alu_*.
- Stage advance: adv = stage_valid & (owner slot empty | owner rs_ready=1 this cycle).
- Accept: can_accept = ~stage_valid | adv.
- Arbitration, when can_accept:
  - Only one rq valid: that requester gets ready=1.
  - Both valid: requester rr_ptr gets ready=1, the other gets ready=0.
  - rqX_ready depends on the valids, so requesters must not make valid depend on ready.
  - Once asserted, valid and payload stay stable until the request is accepted.
- rr_ptr update: on each accept, rr_ptr <= ~granted id. Unchanged when nothing is accepted.
- Timing:
  - Cycle N: rqX_valid & rqX_ready → issue stage loaded at edge N+1.
  - Cycle N+1: ALU combinational.
  - Edge N+2: owner slot captures alu_result1, alu_result2, alu_zero, err = (op > OP_MAX); rsX_valid=1 from cycle N+2.
- Illegal op: still issued. The slot returns whatever the ALU produced, with err=1.
- Response slot: holds until rsX_ready=1 while rsX_valid=1. Clearing and refilling the same slot in the same cycle is allowed; the new data wins and valid stays 1.
- Stall: a full slot with rs_ready=0 blocks the stage when the stage belongs to that owner. A full stage blocks all accepts. No request or result is ever dropped or duplicated.
- Back-to-back: with both rs_ready held at 1, sustained throughput is 1 op/cycle. Alternating grants under contention give a 1:1 split.
- Reset mid-operation discards the stage and both slots; no response is emitted for in-flight operations.

Decomposition:
- Package alu_ctrl_pkg:
  - op code constants OP_ADD=0000, OP_SUB=0001, OP_MOD=0010, OP_MUL=0011, OP_SLL=0100, OP_SRL=0101, OP_OR=0110, OP_AND=0111, OP_XOR=1000;
  - OP_MAX;
  - requester-id constants REQ_EX=0, REQ_AG=1.
- Sub-module rr_arbiter2: 2-way round-robin grant with rr_ptr register and update-on-accept input. Reused by later shared-resource blocks.

Test Plan:
- Single op: rq0 op=0000 a=2 b=2 accepted at cycle 1 → rs0_valid at cycle 3, result1=4, zero=0, err=0; rs1_valid stays 0.
- Contention: both valid from cycle 1, rq0 SUB 3-3, rq1 AND 0x0F0F0F0F & 0xF0F0F0F0, after reset.
  - rq0 is granted first → rs0 result1=0, zero=1.
  - rq1 is granted next cycle → rs1 result1=0, zero=1.
  - Next contended grant goes to rq0.
- Backpressure: rs1_ready=0, rq1 issues two ops (OR 0x0F0F0F0F|0xF0F0F0F0, then XOR 0xAAAAAAAA^0xF0F0F0F0).
  - First op fills the slot; the second sits in the stage; rq0 and rq1 ready go 0.
  - Raise rs1_ready → 0xFFFFFFFF, then 0x5A5A5A5A delivered in order.
- Illegal op: rq0 op=1011 → rs0_valid with err=1 two cycles later; the following legal op returns err=0.
- Reset mid-flight: assert Reset with the stage and rs0 full → next cycle all rs*_valid=0 and rr_ptr=0; no stale response appears after Reset drops.
- Throughput: rq0 issues MUL 64*4, SLL, SRL on consecutive cycles with rs0_ready=1 → rs0_valid high 3 consecutive cycles with the results in order.
